// File: rtl/lfsr_spike_selector_pkg.sv
// Shared types and helpers for the LFSR spike selector and its LFSR sub-block.
package spike_sel_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

  // Maximal-length XNOR tap masks (bit positions are zero-based).
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_xnor.sv
// Fibonacci XNOR LFSR: shift left, feedback into bit 0. All-ones is the lock-up
// state, so a load of all-ones falls back to SEED.
module lfsr_xnor
  import spike_sel_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(53)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);

  localparam logic [15:0] TAPS = lfsr_taps(WIDTH);

  logic fb;
  assign fb = ~(^(value & TAPS[WIDTH-1:0]));

  always_ff @(posedge clk) begin
    if (reset)
      value <= SEED;
    else if (load)
      value <= (&load_val) ? SEED : load_val;
    else if (step)
      value <= {value[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/lfsr_spike_selector.sv
// Picks one active neuron per request: random in-range start index drawn from an
// LFSR by rejection, then round-robin scan. Optional seed port: SPIKE_SELECTOR_SEED_LOAD_EN.
module lfsr_spike_selector
  import spike_sel_pkg::*;
#(
  parameter int NUM_NEURONS = 100,
  parameter int LFSR_WIDTH  = 7,
  parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(53)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_NEURONS-1:0]            spikes,
`ifdef SPIKE_SELECTOR_SEED_LOAD_EN
  input  logic                              seed_load,
  input  logic [LFSR_WIDTH-1:0]             seed_in,
`endif
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic [idx_w(NUM_NEURONS)-1:0]     index
);

  localparam int IDX_W = idx_w(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  if (LFSR_WIDTH < 3 || LFSR_WIDTH > 16) begin : g_bad_width
    $error("lfsr_spike_selector: LFSR_WIDTH must be 3..16");
  end
  if (NUM_NEURONS > (2 ** LFSR_WIDTH) - 1) begin : g_bad_n
    $error("lfsr_spike_selector: NUM_NEURONS exceeds LFSR range");
  end
  if (&SEED) begin : g_bad_seed
    $error("lfsr_spike_selector: SEED must not be all-ones");
  end

  state_t                 state;
  logic [NUM_NEURONS-1:0] spike_reg;
  logic [IDX_W-1:0]       ptr;
  logic [LFSR_WIDTH-1:0]  lfsr_val;
  logic                   lfsr_load;
  logic [LFSR_WIDTH-1:0]  lfsr_load_val;
  logic                   hold_idle;

`ifdef SPIKE_SELECTOR_SEED_LOAD_EN
  assign lfsr_load     = (state == IDLE) && seed_load;
  assign lfsr_load_val = seed_in;
  assign hold_idle     = seed_load;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
  assign hold_idle     = 1'b0;
`endif

  lfsr_xnor #(.WIDTH(LFSR_WIDTH), .SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .step     (state == DRAW),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .value    (lfsr_val)
  );

  // done/found/index are set on the transition into DONE, so done is high
  // exactly while the FSM sits in DONE and a start in that cycle is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      spike_reg <= '0;
      ptr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      index     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!hold_idle && start) begin
            spike_reg <= spikes;
            busy      <= 1'b1;
            if (spikes == '0) begin
              state <= DONE;
              found <= 1'b0;
              index <= '0;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
            end
          end
        end
        DRAW: begin
          if (32'(lfsr_val) < NUM_NEURONS) begin
            ptr   <= IDX_W'(lfsr_val);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (spike_reg[ptr]) begin
            index <= ptr;
            found <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
